// File: rtl/dds_pkg.sv
// Shared types and constants for the DDS tuning-word update path.
package dds_pkg;

  localparam int ADDR_W   = 11;
  localparam int TW_W     = 32;
  localparam int MAX_ADDR = 1800;

  localparam logic [2:0] MODE_4 = 3'd4;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    FETCH,
    WAIT_WRAP,
    APPLY
  } state_t;

endpackage

// File: rtl/dds_req_latch.sv
// Request capture for frequency updates: address clamp, latched address,
// mode-change detect and the pending flag used to coalesce requests.
module dds_req_latch #(
  parameter int ADDR_W   = 11,
  parameter int MAX_ADDR = 1800
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freq_chng,
  input  logic [ADDR_W-1:0] address,
  input  logic [2:0]        mode,
  input  logic [2:0]        mode_out,
  input  logic              idle,
  input  logic              clear_pend,
  output logic              req,
  output logic [ADDR_W-1:0] addr_next,
  output logic              pending
);

  logic [ADDR_W-1:0] addr_clamped;
  logic [ADDR_W-1:0] addr_lat;
  logic [2:0]        mode_d;
  logic              mode_req;

  assign addr_clamped = (address > ADDR_W'(MAX_ADDR)) ? ADDR_W'(MAX_ADDR) : address;

  // While idle a mode mismatch against the applied mode is a request; once an
  // update is in flight only a fresh edge on Mode counts, otherwise the mode
  // being fetched would keep re-arming the pending flag.
  assign mode_req  = idle ? (mode != mode_out) : (mode != mode_d);
  assign req       = freq_chng | mode_req;
  assign addr_next = freq_chng ? addr_clamped : addr_lat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_lat <= '0;
      mode_d   <= '0;
      pending  <= 1'b0;
    end else begin
      addr_lat <= addr_next;
      mode_d   <= mode;
      if (clear_pend)
        pending <= 1'b0;
      else if (!idle && req)
        pending <= 1'b1;
    end
  end

endmodule

// File: rtl/dds_tune_ctrl.sv
// Fetches tuning words from the frequency ROM and applies them to the phase
// accumulator only on a phase wrap (or after a timeout), coalescing requests.
module dds_tune_ctrl #(
  parameter int ADDR_W   = dds_pkg::ADDR_W,
  parameter int TW_W     = dds_pkg::TW_W,
  parameter int ROM_LAT  = 2,
  parameter int MAX_ADDR = dds_pkg::MAX_ADDR,
  parameter int WRAP_TMO = 4096
) (
  input  logic              Fg_clk,
  input  logic              Reset,
  input  logic [2:0]        Mode,
  input  logic              FreqChng,
  input  logic [ADDR_W-1:0] address,
  input  logic              phase_wrap,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [TW_W-1:0]   rom_data,
  output logic [TW_W-1:0]   tw_out,
  output logic [2:0]        mode_out,
  output logic              tw_load,
  output logic              busy
);

  import dds_pkg::state_t;
  import dds_pkg::IDLE;
  import dds_pkg::READ;
  import dds_pkg::FETCH;
  import dds_pkg::WAIT_WRAP;
  import dds_pkg::APPLY;

  localparam int TMO_W = (WRAP_TMO > 2) ? $clog2(WRAP_TMO) : 1;

  state_t            state;
  logic              req;
  logic              pending;
  logic [ADDR_W-1:0] addr_next;
  logic [2:0]        lat_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [TW_W-1:0]   staged_tw;
  logic [2:0]        staged_mode;

  dds_req_latch #(
    .ADDR_W   (ADDR_W),
    .MAX_ADDR (MAX_ADDR)
  ) u_req_latch (
    .clk        (Fg_clk),
    .rst        (Reset),
    .freq_chng  (FreqChng),
    .address    (address),
    .mode       (Mode),
    .mode_out   (mode_out),
    .idle       (state == IDLE),
    .clear_pend (state == APPLY),
    .req        (req),
    .addr_next  (addr_next),
    .pending    (pending)
  );

  // Strobes and loaded values are set on the edge entering READ/APPLY so that
  // every output is a plain register.
  always_ff @(posedge Fg_clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      rom_en      <= 1'b0;
      rom_addr    <= '0;
      tw_out      <= '0;
      mode_out    <= '0;
      tw_load     <= 1'b0;
      busy        <= 1'b0;
      lat_cnt     <= '0;
      tmo_cnt     <= '0;
      staged_tw   <= '0;
      staged_mode <= '0;
    end else begin
      rom_en  <= 1'b0;
      tw_load <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            state    <= READ;
            rom_en   <= 1'b1;
            rom_addr <= addr_next;
            busy     <= 1'b1;
          end
        end
        READ: begin
          staged_mode <= Mode;
          lat_cnt     <= '0;
          state       <= FETCH;
        end
        FETCH: begin
          if (lat_cnt == 3'(ROM_LAT - 1)) begin
            staged_tw <= rom_data;
            tmo_cnt   <= '0;
            state     <= WAIT_WRAP;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        WAIT_WRAP: begin
          if (phase_wrap || tmo_cnt == TMO_W'(WRAP_TMO - 1)) begin
            tw_out   <= staged_tw;
            mode_out <= staged_mode;
            tw_load  <= 1'b1;
            tmo_cnt  <= '0;
            state    <= APPLY;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        APPLY: begin
          // A request arriving in this very cycle is served directly by the
          // refetch, so it is folded in with the pending flag.
          if (pending || req) begin
            state    <= READ;
            rom_en   <= 1'b1;
            rom_addr <= addr_next;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dds_tune_ctrl.sv
// Scoreboard bench for dds_tune_ctrl with a latency-accurate ROM model.
module tb_dds_tune_ctrl;
  import dds_pkg::*;

  localparam int ROM_LAT  = 2;
  localparam int WRAP_TMO = 16;

  logic              Fg_clk = 1'b0;
  logic              Reset;
  logic [2:0]        Mode;
  logic              FreqChng;
  logic [ADDR_W-1:0] address;
  logic              phase_wrap;
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [TW_W-1:0]   rom_data;
  logic [TW_W-1:0]   tw_out;
  logic [2:0]        mode_out;
  logic              tw_load;
  logic              busy;

  dds_tune_ctrl #(
    .ROM_LAT  (ROM_LAT),
    .WRAP_TMO (WRAP_TMO)
  ) dut (
    .Fg_clk     (Fg_clk),
    .Reset      (Reset),
    .Mode       (Mode),
    .FreqChng   (FreqChng),
    .address    (address),
    .phase_wrap (phase_wrap),
    .rom_en     (rom_en),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .tw_out     (tw_out),
    .mode_out   (mode_out),
    .tw_load    (tw_load),
    .busy       (busy)
  );

  always #5 Fg_clk = ~Fg_clk;

  typedef struct packed {
    logic [TW_W-1:0] tw;
    logic [2:0]      mode;
  } load_t;

  logic [ADDR_W-1:0] rd_q[$];
  load_t             ld_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_rd = 0;
  int n_ld = 0;
  int last_rd_cyc = 0;
  int last_ld_cyc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [TW_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    if (a == 11'd100) return 32'h0000_1000;
    return {8'hA5, 5'd0, a, 8'h3C};
  endfunction

  // ROM: word for the address strobed at an edge is valid ROM_LAT cycles later.
  logic [TW_W-1:0] rom_pipe [ROM_LAT];
  always @(posedge Fg_clk) begin
    rom_pipe[0] <= rom_en ? rom_word(rom_addr) : 32'hDEAD_BEEF;
    for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign rom_data = rom_pipe[ROM_LAT-1];

  always @(posedge Fg_clk) cyc <= cyc + 1;

  always @(negedge Fg_clk) begin
    if (rom_en) begin
      n_rd++;
      last_rd_cyc = cyc;
      if (rd_q.size() == 0) check("unexpected_rom_en", 1, 0);
      else check("rom_addr", rom_addr, rd_q.pop_front());
    end
    if (tw_load) begin
      load_t e;
      n_ld++;
      last_ld_cyc = cyc;
      if (ld_q.size() == 0) check("unexpected_tw_load", 1, 0);
      else begin
        e = ld_q.pop_front();
        check("tw_out", tw_out, e.tw);
        check("mode_out", mode_out, e.mode);
      end
    end
  end

  task automatic send_req(input logic [ADDR_W-1:0] a, output int c);
    FreqChng = 1'b1;
    address  = a;
    c        = cyc;
    @(negedge Fg_clk);
    FreqChng = 1'b0;
  endtask

  task automatic goto_cyc(input int c);
    while (cyc < c) @(negedge Fg_clk);
  endtask

  task automatic pulse_wrap();
    phase_wrap = 1'b1;
    @(negedge Fg_clk);
    phase_wrap = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    for (int i = 0; i < max_cyc && busy; i++) @(negedge Fg_clk);
    check(tag, busy, 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_rom_en"}, rom_en, 0);
    check({tag, "_rom_addr"}, rom_addr, 0);
    check({tag, "_tw_out"}, tw_out, 0);
    check({tag, "_mode_out"}, mode_out, 0);
    check({tag, "_tw_load"}, tw_load, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int c, c2;
    int ld0, rd0;
    Reset = 1'b1; Mode = '0; FreqChng = 1'b0; address = '0; phase_wrap = 1'b0;
    repeat (3) @(negedge Fg_clk);
    check_zero_outputs("reset");
    Reset = 1'b0;
    @(negedge Fg_clk);

    // single request, wrap 10 cycles after capture
    rd_q.push_back(11'd100);
    ld_q.push_back('{tw: 32'h0000_1000, mode: 3'd0});
    send_req(11'd100, c);
    goto_cyc(c + 1 + ROM_LAT + 10);
    pulse_wrap();
    wait_idle("single_idle", 50);
    check("single_rd_lat", last_rd_cyc - c, 1);
    check("single_ld_lat", last_ld_cyc - c, ROM_LAT + 12);

    // clamp, wrap on the first WAIT_WRAP cycle (best-case latency)
    rd_q.push_back(11'(MAX_ADDR));
    ld_q.push_back('{tw: rom_word(11'(MAX_ADDR)), mode: 3'd0});
    send_req(11'd2000, c);
    goto_cyc(c + 2 + ROM_LAT);
    pulse_wrap();
    wait_idle("clamp_idle", 50);
    check("clamp_ld_lat", last_ld_cyc - c, ROM_LAT + 3);

    // coalescing: 6 and 7 arrive while the word for 5 waits for a wrap
    ld0 = n_ld; rd0 = n_rd;
    rd_q.push_back(11'd5);
    ld_q.push_back('{tw: rom_word(11'd5), mode: 3'd0});
    rd_q.push_back(11'd7);
    ld_q.push_back('{tw: rom_word(11'd7), mode: 3'd0});
    send_req(11'd5, c);
    goto_cyc(c + 3 + ROM_LAT);
    send_req(11'd6, c2);
    send_req(11'd7, c2);
    for (int i = 0; i < 100 && busy; i++) begin
      phase_wrap = (i % 5 == 4);
      @(negedge Fg_clk);
    end
    phase_wrap = 1'b0;
    check("coalesce_idle", busy, 0);
    check("coalesce_loads", n_ld - ld0, 2);
    check("coalesce_reads", n_rd - rd0, 2);

    // timeout with no wrap at all
    rd_q.push_back(11'd300);
    ld_q.push_back('{tw: rom_word(11'd300), mode: 3'd0});
    send_req(11'd300, c);
    wait_idle("timeout_idle", 60);
    check("timeout_ld_lat", last_ld_cyc - c, ROM_LAT + 2 + WRAP_TMO);

    // reset while in FETCH: fetch discarded, no load afterwards
    ld0 = n_ld; rd0 = n_rd;
    rd_q.push_back(11'd50);
    send_req(11'd50, c);
    goto_cyc(c + 2);
    Reset = 1'b1;
    @(negedge Fg_clk);
    check_zero_outputs("midreset");
    Reset = 1'b0;
    for (int i = 0; i < 30; i++) begin
      phase_wrap = (i % 4 == 1);
      @(negedge Fg_clk);
    end
    phase_wrap = 1'b0;
    check("midreset_loads", n_ld - ld0, 0);
    check("midreset_reads", n_rd - rd0, 1);
    check("midreset_tw_out", tw_out, 0);

    // mode change alone refetches the latched address (0 after reset)
    rd_q.push_back(11'd0);
    ld_q.push_back('{tw: rom_word(11'd0), mode: MODE_4});
    Mode = MODE_4;
    c = cyc;
    @(negedge Fg_clk);
    wait_idle("mode_idle", 60);
    check("mode_ld_lat", last_ld_cyc - c, ROM_LAT + 2 + WRAP_TMO);
    check("mode_out_final", mode_out, MODE_4);
    check("tw_out_final", tw_out, rom_word(11'd0));

    repeat (3) @(negedge Fg_clk);
    check("rd_queue_left", rd_q.size(), 0);
    check("ld_queue_left", ld_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
